// File: rtl/usb_setup_decoder.sv
// Captures 8-byte USB SETUP packets and decodes Bulk-Only MSD class requests (Mass Storage Reset,
// Get Max LUN). It also writes the Get Max LUN response byte, with a bounded wait on FIFO back-pressure.
module usb_setup_decoder #(
    parameter logic [7:0] MSD_LUN_NUM  = 8'd0,
    parameter logic [7:0] MSD_INTF_NUM = 8'd0,
    parameter int         RSP_WAIT_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        setup_i,
    input  logic        rxval_i,
    input  logic [7:0]  rxdat_i,
    output logic [7:0]  rsp_tx_dat_o,
    output logic        rsp_tx_ena_o,
    input  logic        rsp_tx_full_i,
    output logic        rsp_tx_err_o,
    output logic        req_val_o,
    output logic [7:0]  req_type_o,
    output logic [7:0]  req_code_o,
    output logic [15:0] req_value_o,
    output logic [15:0] req_index_o,
    output logic [15:0] req_length_o,
    output logic        req_stall_o,
    output logic        msd_rst_req_o,
    output logic        msd_get_max_lun_req_o
);
    localparam int WW = $clog2(RSP_WAIT_MAX) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(RSP_WAIT_MAX - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RECV     = 2'd1;
    localparam logic [1:0] ST_DECODE   = 2'd2;
    localparam logic [1:0] ST_RSP_WAIT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          setup_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    buf_q [0:7];
    logic          byte_we;
    logic [2:0]    byte_idx;
    logic          take;

    logic val_q, val_d, stall_q, stall_d, mrst_q, mrst_d, gml_q, gml_d, ena_q, ena_d, err_q, err_d;

    logic [7:0]  b_type, b_code;
    logic [15:0] b_value, b_index, b_length;
    logic        target, is_mrst, is_gml;

    assign b_type   = buf_q[0];
    assign b_code   = buf_q[1];
    assign b_value  = {buf_q[3], buf_q[2]};
    assign b_index  = {buf_q[5], buf_q[4]};
    assign b_length = {buf_q[7], buf_q[6]};

    assign target  = (b_type[6:5] == 2'b01) && (b_type[4:0] == 5'd1) &&
                     (b_index == {8'h00, MSD_INTF_NUM});
    assign is_mrst = target && (b_type == 8'h21) && (b_code == 8'hFF) &&
                     (b_value == 16'd0) && (b_length == 16'd0);
    assign is_gml  = target && (b_type == 8'hA1) && (b_code == 8'hFE) &&
                     (b_value == 16'd0) && (b_length == 16'd1);

    assign take = setup_i && rxval_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        byte_we  = 1'b0;
        byte_idx = 3'd0;
        val_d    = 1'b0;
        stall_d  = 1'b0;
        mrst_d   = 1'b0;
        gml_d    = 1'b0;
        ena_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup_i) begin
                    state_d = ST_RECV;
                    cnt_d   = take ? 4'd1 : 4'd0;
                    byte_we = take;
                end
            end
            ST_RECV: begin
                if (setup_i) begin
                    if (take) begin
                        byte_we  = (cnt_q < 4'd8);
                        byte_idx = cnt_q[2:0];
                        cnt_d    = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
                    end
                end else begin
                    // Only an exact 8-byte packet is decoded; anything else is dropped silently.
                    state_d = (setup_q && cnt_q == 4'd8) ? ST_DECODE : ST_IDLE;
                end
            end
            ST_DECODE: begin
                val_d   = 1'b1;
                mrst_d  = is_mrst;
                gml_d   = is_gml;
                stall_d = target && !is_mrst && !is_gml;
                wait_d  = '0;
                state_d = is_gml ? ST_RSP_WAIT : ST_IDLE;
            end
            default: begin
                // A new SETUP pre-empts the pending response.
                if (setup_i) begin
                    state_d = ST_RECV;
                    cnt_d   = take ? 4'd1 : 4'd0;
                    byte_we = take;
                end else if (!rsp_tx_full_i) begin
                    ena_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            setup_q      <= 1'b0;
            cnt_q        <= 4'd0;
            wait_q       <= '0;
            val_q        <= 1'b0;
            stall_q      <= 1'b0;
            mrst_q       <= 1'b0;
            gml_q        <= 1'b0;
            ena_q        <= 1'b0;
            err_q        <= 1'b0;
            req_type_o   <= 8'd0;
            req_code_o   <= 8'd0;
            req_value_o  <= 16'd0;
            req_index_o  <= 16'd0;
            req_length_o <= 16'd0;
            for (int i = 0; i < 8; i++) buf_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            setup_q <= setup_i;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            val_q   <= val_d;
            stall_q <= stall_d;
            mrst_q  <= mrst_d;
            gml_q   <= gml_d;
            ena_q   <= ena_d;
            err_q   <= err_d;
            if (byte_we) buf_q[byte_idx] <= rxdat_i;
            if (state_q == ST_DECODE) begin
                req_type_o   <= b_type;
                req_code_o   <= b_code;
                req_value_o  <= b_value;
                req_index_o  <= b_index;
                req_length_o <= b_length;
            end
        end
    end

    assign rsp_tx_dat_o          = MSD_LUN_NUM;
    assign rsp_tx_ena_o          = ena_q;
    assign rsp_tx_err_o          = err_q;
    assign req_val_o             = val_q;
    assign req_stall_o           = stall_q;
    assign msd_rst_req_o         = mrst_q;
    assign msd_get_max_lun_req_o = gml_q;
endmodule

// File: tb/tb_usb_setup_decoder.sv
// Directed bench for usb_setup_decoder: inputs change on the falling edge, outputs are sampled there too.
module tb_usb_setup_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        setup = 1'b0;
    logic        rxval = 1'b0;
    logic [7:0]  rxdat = 8'd0;
    logic        full = 1'b0;
    logic [7:0]  dat;
    logic        ena, err, val, stall, mrst, gml;
    logic [7:0]  rtype, rcode;
    logic [15:0] rvalue, rindex, rlength;

    int checks = 0;
    int failures = 0;
    logic bad;

    always #5 clk = ~clk;

    usb_setup_decoder #(
        .MSD_LUN_NUM (8'd3),
        .MSD_INTF_NUM(8'd0),
        .RSP_WAIT_MAX(16)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .setup_i              (setup),
        .rxval_i              (rxval),
        .rxdat_i              (rxdat),
        .rsp_tx_dat_o         (dat),
        .rsp_tx_ena_o         (ena),
        .rsp_tx_full_i        (full),
        .rsp_tx_err_o         (err),
        .req_val_o            (val),
        .req_type_o           (rtype),
        .req_code_o           (rcode),
        .req_value_o          (rvalue),
        .req_index_o          (rindex),
        .req_length_o         (rlength),
        .req_stall_o          (stall),
        .msd_rst_req_o        (mrst),
        .msd_get_max_lun_req_o(gml)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte i of the packet is p[63-8*i -: 8]; a 9th byte, if requested, is 8'h55.
    task automatic send(input logic [63:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            setup = 1'b1;
            rxval = 1'b1;
            rxdat = (i < 8) ? p[63-8*i -: 8] : 8'h55;
        end
        @(negedge clk);
        setup = 1'b0;
        rxval = 1'b0;
    endtask

    // Returns with bad=1 if any pulse output was seen during the next n falling edges.
    task automatic watch_quiet(input int n);
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (val | stall | mrst | gml | ena | err) bad = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst_val", val, 1'b0);
        chk1("rst_ena", ena, 1'b0);
        chk16("rst_type", {8'd0, rtype}, 16'h0000);
        chk16("rst_len", rlength, 16'h0000);
        chk16("dat_const", {8'd0, dat}, 16'h0003);
        rst = 1'b0;

        // 1: Get Max LUN, FIFO free
        send(64'hA1FE000000000100, 8);
        @(negedge clk);
        chk1("gml_early_val", val, 1'b0);
        @(negedge clk);
        chk1("gml_val", val, 1'b1);
        chk1("gml_pulse", gml, 1'b1);
        chk1("gml_nostall", stall, 1'b0);
        chk16("gml_type", {8'd0, rtype}, 16'h00A1);
        chk16("gml_code", {8'd0, rcode}, 16'h00FE);
        chk16("gml_len", rlength, 16'h0001);
        chk1("gml_ena_not_yet", ena, 1'b0);
        @(negedge clk);
        chk1("gml_ena", ena, 1'b1);
        chk16("gml_dat", {8'd0, dat}, 16'h0003);
        chk1("gml_val_1cyc", val, 1'b0);
        @(negedge clk);
        chk1("gml_ena_1cyc", ena, 1'b0);

        // 2: Mass Storage Reset
        send(64'h21FF000000000000, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("mrst_pulse", mrst, 1'b1);
        chk1("mrst_nogml", gml, 1'b0);
        chk1("mrst_nostall", stall, 1'b0);
        @(negedge clk);
        chk1("mrst_1cyc", mrst, 1'b0);
        chk1("mrst_noena", ena, 1'b0);

        // 3a: Get Max LUN with wLength=2 -> stall
        send(64'hA1FE000000000200, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("badlen_stall", stall, 1'b1);
        chk1("badlen_nogml", gml, 1'b0);
        @(negedge clk);
        chk1("badlen_noena", ena, 1'b0);
        chk1("badlen_stall_1cyc", stall, 1'b0);

        // 3b: other interface -> req_val only
        send(64'h21FE000001000000, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("otherif_val", val, 1'b1);
        chk1("otherif_nostall", stall, 1'b0);
        chk1("otherif_nomrst", mrst, 1'b0);
        chk16("otherif_index", rindex, 16'h0001);

        // 4a: FIFO full throughout -> error after 16 attempts
        full = 1'b1;
        send(64'hA1FE000000000100, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("full_gml", gml, 1'b1);
        watch_quiet(15);
        chk1("full_no_early_out", bad, 1'b0);
        @(negedge clk);
        chk1("full_err", err, 1'b1);
        chk1("full_noena", ena, 1'b0);
        @(negedge clk);
        chk1("full_err_1cyc", err, 1'b0);

        // 4b: FIFO released after 3 full cycles -> write on release
        send(64'hA1FE000000000100, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("rel_gml", gml, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk1("rel_noena_yet", ena, 1'b0);
        full = 1'b0;
        @(negedge clk);
        chk1("rel_ena", ena, 1'b1);
        chk1("rel_noerr", err, 1'b0);
        watch_quiet(20);
        chk1("rel_no_late_err", bad, 1'b0);

        // 5: 7-byte and 9-byte packets are discarded
        send(64'h21FF000000000000, 7);
        watch_quiet(5);
        chk1("short_quiet", bad, 1'b0);
        chk16("short_type_held", {8'd0, rtype}, 16'h00A1);
        send(64'h21FF000000000000, 9);
        watch_quiet(5);
        chk1("long_quiet", bad, 1'b0);
        chk16("long_type_held", {8'd0, rtype}, 16'h00A1);
        chk16("long_len_held", rlength, 16'h0001);

        // 6a: reset in the middle of a packet
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            setup = 1'b1;
            rxval = 1'b1;
            rxdat = 8'h21;
        end
        @(negedge clk);
        rst = 1'b1;
        setup = 1'b0;
        rxval = 1'b0;
        #1;
        chk16("midpkt_rst_type", {8'd0, rtype}, 16'h0000);
        chk16("midpkt_rst_len", rlength, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(5);
        chk1("midpkt_quiet", bad, 1'b0);

        // 6b: reset while waiting on a full FIFO
        full = 1'b1;
        send(64'hA1FE000000000100, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("wait_gml", gml, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("wait_rst_val", val, 1'b0);
        chk16("wait_rst_len", rlength, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        full = 1'b0;
        watch_quiet(20);
        chk1("wait_rst_quiet", bad, 1'b0);

        // Recovery: a good packet still decodes
        send(64'hA1FE000000000100, 8);
        @(negedge clk);
        @(negedge clk);
        chk1("recover_gml", gml, 1'b1);
        chk16("recover_len", rlength, 16'h0001);
        @(negedge clk);
        chk1("recover_ena", ena, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
